// File: rtl/work_dispatcher.sv
// Front end for block_solver: buffers one 76-byte job from a byte stream, launches a
// solve by pulsing solver_rst_n, and returns a 5-byte status/nonce frame with a timeout.
module work_dispatcher #(
   parameter int unsigned START_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [255:0] midstate,
   output logic [95:0]  header_leftovers,
   output logic [255:0] target,
   output logic         solver_rst_n,
   input  logic [1:0]   state_out,
   input  logic [31:0]  nonce,
   output logic         busy
);
   localparam int unsigned MID_W     = 256;
   localparam int unsigned HL_W      = 96;
   localparam int unsigned TGT_W     = 256;
   localparam int unsigned JOB_BYTES = 76;
   localparam int unsigned JOB_W     = JOB_BYTES * 8;
   localparam int unsigned CNT_W     = 7;
   localparam int unsigned SC_W      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int unsigned TMO_W     = 32;
   localparam int unsigned NONCE_W   = 32;
   localparam int unsigned IDX_W     = 3;

   localparam logic [7:0] ST_FOUND   = 8'h01;
   localparam logic [7:0] ST_EXHAUST = 8'h02;
   localparam logic [7:0] ST_TIMEOUT = 8'h03;

   typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_t;

   state_t               state_q, state_d;
   logic [SC_W-1:0]      start_cnt_q, start_cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
   logic                 tx_valid_d, solver_rst_n_d, busy_d;
   logic [7:0]           tx_data_d;
   logic                 load_c, report_c;
   logic [7:0]           status_c;

   logic [JOB_W-1:0]     shadow_q;
   logic [CNT_W-1:0]     byte_cnt_q;
   logic                 shadow_full;

   assign shadow_full = ~rx_ready;

   // Shadow buffer: bytes shift in MSB-first; rx_ready doubles as "shadow empty"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q   <= '0;
         byte_cnt_q <= '0;
         rx_ready   <= 1'b1;
      end else begin
         if (load_c) rx_ready <= 1'b1;
         if (rx_valid && rx_ready) begin
            shadow_q <= {shadow_q[JOB_W-9:0], rx_data};
            if (byte_cnt_q == CNT_W'(JOB_BYTES - 1)) begin
               byte_cnt_q <= '0;
               rx_ready   <= 1'b0;
            end else begin
               byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Job registers seen by the solver; they only move on a load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         midstate         <= '0;
         header_leftovers <= '0;
         target           <= '0;
      end else if (load_c) begin
         midstate         <= shadow_q[JOB_W-1 -: MID_W];
         header_leftovers <= shadow_q[TGT_W +: HL_W];
         target           <= shadow_q[TGT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         start_cnt_q  <= '0;
         tmo_q        <= '0;
         nonce_q      <= '0;
         byte_idx_q   <= '0;
         tx_valid     <= 1'b0;
         tx_data      <= '0;
         solver_rst_n <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_cnt_q  <= start_cnt_d;
         tmo_q        <= tmo_d;
         nonce_q      <= nonce_d;
         byte_idx_q   <= byte_idx_d;
         tx_valid     <= tx_valid_d;
         tx_data      <= tx_data_d;
         solver_rst_n <= solver_rst_n_d;
         busy         <= busy_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      start_cnt_d    = start_cnt_q;
      tmo_d          = tmo_q;
      nonce_d        = nonce_q;
      byte_idx_d     = byte_idx_q;
      tx_valid_d     = tx_valid;
      tx_data_d      = tx_data;
      solver_rst_n_d = solver_rst_n;
      load_c         = 1'b0;
      report_c       = 1'b0;
      status_c       = ST_TIMEOUT;

      case (state_q)
         IDLE: begin
            solver_rst_n_d = 1'b0;
            if (shadow_full) load_c = 1'b1;
         end
         START: begin
            if (start_cnt_q == '0) begin
               state_d        = RUN;
               solver_rst_n_d = 1'b1;
               tmo_d          = '0;
            end else begin
               start_cnt_d = start_cnt_q - SC_W'(1);
            end
         end
         RUN: begin
            if (tmo_q != '1) tmo_d = tmo_q + TMO_W'(1);
            // tmo_q == 0 is the solver's reset-exit clock, so state_out is stale there
            if (tmo_q != '0 && state_out == 2'b01) begin
               report_c = 1'b1;
               status_c = ST_FOUND;
            end else if (tmo_q != '0 && state_out == 2'b10) begin
               report_c = 1'b1;
               status_c = ST_EXHAUST;
            end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               report_c = 1'b1;
               status_c = ST_TIMEOUT;
            end
            if (report_c) begin
               state_d        = REPORT;
               nonce_d        = nonce;
               tx_valid_d     = 1'b1;
               tx_data_d      = status_c;
               byte_idx_d     = '0;
               solver_rst_n_d = 1'b0;
            end
         end
         REPORT: begin
            solver_rst_n_d = 1'b0;
            if (tx_valid && tx_ready) begin
               if (byte_idx_q == IDX_W'(4)) begin
                  tx_valid_d = 1'b0;
                  byte_idx_d = '0;
                  if (shadow_full) load_c = 1'b1;
                  else state_d = IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + IDX_W'(1);
                  case (byte_idx_q)
                     IDX_W'(0): tx_data_d = nonce_q[31:24];
                     IDX_W'(1): tx_data_d = nonce_q[23:16];
                     IDX_W'(2): tx_data_d = nonce_q[15:8];
                     default:   tx_data_d = nonce_q[7:0];
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Load is shared by IDLE and the tail of REPORT so a pending job starts without an idle cycle
      if (load_c) begin
         state_d        = START;
         start_cnt_d    = SC_W'(START_CYCLES - 1);
         solver_rst_n_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end
endmodule
